// File: rtl/eprom_access_arbiter.sv
// eprom_access_arbiter: shares one 2732 EPROM between the video fetch path and the CPU.
// The winner's address is driven, E/G are held low for a fixed window, and the byte is captured.
module eprom_access_arbiter #(
  parameter int ADDR_W          = 12,
  parameter int DATA_W          = 8,
  parameter int ACCESS_CYCLES   = 3,
  parameter int RECOVERY_CYCLES = 1,
  parameter int MAX_VID_BURST   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [DATA_W-1:0] vid_data,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_e_n,
  output logic              rom_g_n,
  input  logic [DATA_W-1:0] rom_q,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE,
    RECOVER
  } state_t;

  localparam logic [3:0] ACC_LAST = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0] REC_LAST = 4'(RECOVERY_CYCLES - 1);
  localparam logic [3:0] MAX_B    = 4'(MAX_VID_BURST);

  state_t            state;
  state_t            state_d;
  logic [3:0]        burst;
  logic [3:0]        burst_d;
  logic [3:0]        cnt;
  logic [3:0]        cnt_d;
  logic              win_cpu;
  logic              win_cpu_d;
  logic [ADDR_W-1:0] addr_d;
  logic              grant_vid;
  logic              grant_cpu;
  logic              capture;

  // Arbitration, sequencing and burst tracking.
  always_comb begin
    state_d   = state;
    burst_d   = burst;
    cnt_d     = cnt;
    win_cpu_d = win_cpu;
    addr_d    = rom_addr;
    grant_vid = 1'b0;
    grant_cpu = 1'b0;
    capture   = 1'b0;
    unique case (state)
      IDLE: begin
        grant_cpu = cpu_req &&
                    (!vid_req || burst == MAX_B);
        grant_vid = vid_req && !grant_cpu;
        unique case (1'b1)
          grant_cpu: begin
            win_cpu_d = 1'b1;
            addr_d    = cpu_addr;
            burst_d   = 4'd0;
            state_d   = SETUP;
          end
          grant_vid: begin
            win_cpu_d = 1'b0;
            addr_d    = vid_addr;
            state_d   = SETUP;
            if (!cpu_req)
              burst_d = 4'd0;
            else if (burst != MAX_B)
              burst_d = burst + 4'd1;
          end
          default: ;
        endcase
      end
      SETUP: begin
        cnt_d   = 4'd0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (cnt == ACC_LAST) begin
          capture = 1'b1;
          cnt_d   = 4'd0;
          state_d = DONE;
        end else begin
          cnt_d = cnt + 4'd1;
        end
      end
      DONE: begin
        cnt_d = 4'd0;
        if (RECOVERY_CYCLES == 0)
          state_d = IDLE;
        else
          state_d = RECOVER;
      end
      RECOVER: begin
        if (cnt == REC_LAST) begin
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      burst   <= 4'd0;
      cnt     <= 4'd0;
      win_cpu <= 1'b0;
    end else begin
      state   <= state_d;
      burst   <= burst_d;
      cnt     <= cnt_d;
      win_cpu <= win_cpu_d;
    end
  end

  // Registered EPROM strobes, acks and captured data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr <= '0;
      rom_e_n  <= 1'b1;
      rom_g_n  <= 1'b1;
      busy     <= 1'b0;
      vid_ack  <= 1'b0;
      cpu_ack  <= 1'b0;
      vid_data <= '0;
      cpu_data <= '0;
    end else begin
      rom_addr <= addr_d;
      rom_e_n  <= (state_d != ACCESS);
      rom_g_n  <= (state_d != ACCESS);
      busy     <= (state_d != IDLE);
      vid_ack  <= capture && !win_cpu;
      cpu_ack  <= capture && win_cpu;
      if (capture && win_cpu)
        cpu_data <= rom_q;
      if (capture && !win_cpu)
        vid_data <= rom_q;
    end
  end

endmodule

// File: doc/eprom_access_arbiter.md
Name: eprom_access_arbiter

Overview:
Shares one 2732-style 4K x 8 UV EPROM between two requesters: the video fetch path and the CPU. It arbitrates, then drives the EPROM address and active-low E/G strobes with a programmable access window. It registers the returned byte and acknowledges the winning requester. It sits between the CPU/video buses and the EPROM model.

Parameters:
ADDR_W, 12, EPROM address width
DATA_W, 8, EPROM data width
ACCESS_CYCLES, 3, clocks E/G held low before data capture; legal range 1..15
RECOVERY_CYCLES, 1, clocks with E/G high after a transaction before the next arbitration; legal range 0..15
MAX_VID_BURST, 4, consecutive video grants allowed while CPU is waiting; legal range 1..15

Ports:
clk  in  1  system clock, rising-edge
rst_n  in  1  asynchronous active-low reset
vid_req  in  1  video read request, held until vid_ack
vid_addr  in  ADDR_W  video read address, stable while vid_req high
vid_ack  out  1  one-cycle pulse, vid_data valid
vid_data  out  DATA_W  last byte read for video, held until next vid_ack
cpu_req  in  1  CPU read request, held until cpu_ack
cpu_addr  in  ADDR_W  CPU read address, stable while cpu_req high
cpu_ack  out  1  one-cycle pulse, cpu_data valid
cpu_data  out  DATA_W  last byte read for CPU, held until next cpu_ack
rom_addr  out  ADDR_W  EPROM address A0..A11
rom_e_n  out  1  EPROM chip enable, active low
rom_g_n  out  1  EPROM output enable, active low
rom_q  in  DATA_W  EPROM data Q0..Q7
busy  out  1  high whenever state is not IDLE

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- All outputs are registered.
- Reset values: rom_e_n=1, rom_g_n=1, rom_addr=0, vid_ack=0, cpu_ack=0, vid_data=0, cpu_data=0, busy=0, state=IDLE, burst counter=0, access/recovery counters=0.
- States: IDLE -> SETUP -> ACCESS -> DONE -> RECOVER -> IDLE. DONE goes straight to IDLE when RECOVERY_CYCLES=0.
- IDLE:
  - Samples vid_req and cpu_req.
  - If neither is high, remains in IDLE.
  - Otherwise latches the winner and its address, then goes to SETUP.
- Arbitration (IDLE only):
  - Video alone wins; CPU alone wins.
  - If both are high, video wins unless the burst counter equals MAX_VID_BURST; in that case CPU wins.
- Burst counter (4 bits):
  - Increments on a video grant made while cpu_req is high.
  - Clears on a CPU grant, or on a video grant made while cpu_req is low.
  - Saturates at MAX_VID_BURST.
- SETUP (1 cycle): rom_addr = latched address; rom_e_n and rom_g_n both high.
- ACCESS (ACCESS_CYCLES cycles): rom_e_n=rom_g_n=0; rom_addr held.
- Capture: rom_q is captured into the winner's data register on the rising edge that ends the last ACCESS cycle.
- DONE (1 cycle):
  - Winner's ack=1; rom_e_n/rom_g_n return to 1.
  - rom_addr holds its value until the next SETUP.
- RECOVER: RECOVERY_CYCLES cycles with strobes high.
- Latency: request first seen high in IDLE at cycle N -> ack at cycle N+2+ACCESS_CYCLES (N+5 at defaults).
- Back-to-back period: 3+ACCESS_CYCLES+RECOVERY_CYCLES clocks (7 at defaults).
- Only one ack is ever high in a cycle. The non-granted data register never changes.
- Request deassertion after grant is ignored: the transaction completes and ack still pulses. Deassertion before grant means the request is never served.
- A request still held high in the cycle after its ack is treated as a new request.
- Reset mid-transaction: all outputs go to reset values immediately. The in-flight transaction is discarded with no ack. Requests still high after reset release are served afresh.
- rom_q is ignored outside the capture edge; X/Z on rom_q at other times must not propagate.

Test Plan:
1. Apply reset with both requests high -> during reset: rom_e_n=rom_g_n=1, acks 0, data 0, busy 0. After release: video served first.
2. CPU-only read of 0x005, with the EPROM model returning 0xA5 -> rom_e_n/rom_g_n low exactly in cycles N+2..N+4; cpu_ack pulses at N+5; cpu_data=0xA5; vid_data unchanged.
3. vid_req(0x001) and cpu_req(0x002) raised in the same cycle -> vid_ack with byte[0x001] first; cpu_ack with byte[0x002] 7 cycles later.
4. vid_req and cpu_req both held continuously -> grant order V,V,V,V,C,V,V,V,V,C. No ack overlap; every period is 7 cycles.
5. Assert rst_n low during the second ACCESS cycle of a CPU read -> strobes high asynchronously; no cpu_ack. After release, the still-held cpu_req completes with the correct data.
6. Sequential CPU reads of 0x000..0x009 against a loaded image -> each cpu_data matches the image. cpu_data stays stable while rom_q changes between transactions.
